// File: rtl/obi_mem_arbiter.sv
// Two-host OBI arbiter onto a single device port: host 0 = data port, host 1 = fetch port.
// Round-robin selection, locked while a device request waits for grant; an owner FIFO routes responses.
module obi_mem_arbiter #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                h0_req_i,
  output logic                h0_gnt_o,
  input  logic [ADDR_W-1:0]   h0_addr_i,
  input  logic                h0_we_i,
  input  logic [DATA_W/8-1:0] h0_be_i,
  input  logic [DATA_W-1:0]   h0_wdata_i,
  output logic                h0_rvalid_o,
  output logic [DATA_W-1:0]   h0_rdata_o,
  input  logic                h1_req_i,
  output logic                h1_gnt_o,
  input  logic [ADDR_W-1:0]   h1_addr_i,
  input  logic                h1_we_i,
  input  logic [DATA_W/8-1:0] h1_be_i,
  input  logic [DATA_W-1:0]   h1_wdata_i,
  output logic                h1_rvalid_o,
  output logic [DATA_W-1:0]   h1_rdata_o,
  output logic                dev_req_o,
  input  logic                dev_gnt_i,
  output logic [ADDR_W-1:0]   dev_addr_o,
  output logic                dev_we_o,
  output logic [DATA_W/8-1:0] dev_be_o,
  output logic [DATA_W-1:0]   dev_wdata_o,
  input  logic                dev_rvalid_i,
  input  logic [DATA_W-1:0]   dev_rdata_i,
  output logic                err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  logic              last_reg;
  logic              lock_reg;
  logic              locked_id_reg;
  logic              err_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              owner_mem [MAX_OUTSTANDING];

  logic              sel;
  logic              sel_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              handshake;
  logic              pop;
  logic              head_owner;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    sel = last_reg;
    if (lock_reg) begin
      sel = locked_id_reg;
    end else if (h0_req_i && !h1_req_i) begin
      sel = 1'b0;
    end else if (h1_req_i && !h0_req_i) begin
      sel = 1'b1;
    end else if (h0_req_i && h1_req_i) begin
      sel = ~last_reg;
    end
  end

  assign sel_req    = sel ? h1_req_i : h0_req_i;
  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);

  // Requests are masked while reset is held so nothing leaks onto the device port.
  assign dev_req_o  = sel_req && !fifo_full && rst_ni;
  assign handshake  = dev_req_o && dev_gnt_i;

  assign dev_addr_o  = sel_req ? (sel ? h1_addr_i  : h0_addr_i)  : '0;
  assign dev_we_o    = sel_req ? (sel ? h1_we_i    : h0_we_i)    : 1'b0;
  assign dev_be_o    = sel_req ? (sel ? h1_be_i    : h0_be_i)    : {BE_W{1'b0}};
  assign dev_wdata_o = sel_req ? (sel ? h1_wdata_i : h0_wdata_i) : '0;

  assign h0_gnt_o = handshake && (sel == 1'b0);
  assign h1_gnt_o = handshake && (sel == 1'b1);

  assign pop         = dev_rvalid_i && !fifo_empty;
  assign head_owner  = owner_mem[rd_ptr_reg];
  assign h0_rvalid_o = pop && (head_owner == 1'b0);
  assign h1_rvalid_o = pop && (head_owner == 1'b1);
  assign h0_rdata_o  = dev_rdata_i;
  assign h1_rdata_o  = dev_rdata_i;
  assign err_o       = err_reg;

  // Owner storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      owner_mem[wr_ptr_reg] <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_reg      <= 1'b1;
      lock_reg      <= 1'b0;
      locked_id_reg <= 1'b0;
      err_reg       <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      if (handshake) begin
        lock_reg   <= 1'b0;
        last_reg   <= sel;
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end else if (dev_req_o) begin
        lock_reg      <= 1'b1;
        locked_id_reg <= sel;
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (handshake && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !handshake) begin
        count_reg <= count_reg - CNT_W'(1);
      end
      if (dev_rvalid_i && fifo_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one OBI device port (unified memory or bus bridge) between two OBI hosts: host 0 is the data-memory port, host 1 is the instruction-fetch port.
- Arbitration is round-robin. The selection is locked while a device request is pending and not yet granted.
- Tracks outstanding transactions in order and routes each response (rvalid/rdata) back to the host that issued it.
- Sits between the core's imem/dmem OBI ports and the single external memory interface.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, read/write data width. Byte-enable width is DATA_W/8.
- MAX_OUTSTANDING, 2, depth of the owner FIFO: maximum number of granted but unanswered transactions. Power of two, ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- hN_req_i  in  1  host N request (N = 0, 1; same set for each host)
- hN_gnt_o  out  1  grant to host N
- hN_addr_i  in  ADDR_W  host N address
- hN_we_i  in  1  host N write enable
- hN_be_i  in  DATA_W/8  host N byte enables
- hN_wdata_i  in  DATA_W  host N write data
- hN_rvalid_o  out  1  response valid to host N
- hN_rdata_o  out  DATA_W  response data to host N
- dev_req_o  out  1  device request
- dev_gnt_i  in  1  device grant
- dev_addr_o  out  ADDR_W  device address
- dev_we_o  out  1  device write enable
- dev_be_o  out  DATA_W/8  device byte enables
- dev_wdata_o  out  DATA_W  device write data
- dev_rvalid_i  in  1  device response valid
- dev_rdata_i  in  DATA_W  device response data
- err_o  out  1  sticky protocol error: rvalid received with no transaction outstanding

Behaviour:
- Reset (async assert, synchronous deassert by integrator):
  - Owner FIFO empty, count 0.
  - Last-granted pointer = 1, so host 0 wins the first tie.
  - Lock cleared, err_o = 0.
  - All gnt, rvalid and dev_req outputs are 0 while reset is asserted, because the FIFO is empty and requests are masked.
  - Reset mid-transaction discards all owner entries. Late rvalids after reset set err_o.
- Selection (combinational), sel:
  - If lock is set, sel = locked_id.
  - Otherwise, if only one host requests, sel = that host.
  - If both request, sel = the host not granted last.
  - If neither requests, sel = last-granted and dev_req_o = 0.
- dev_req_o = hsel_req_i AND NOT fifo_full.
  - dev_addr/we/be/wdata are muxed from sel. They are 0 when no host is requesting.
- hN_gnt_o = dev_gnt_i AND dev_req_o AND (sel==N). Zero-cycle pass-through: no extra latency.
- Lock:
  - Set on a cycle with dev_req_o=1 and dev_gnt_i=0; locked_id = sel.
  - Cleared on a handshake (dev_req_o & dev_gnt_i).
  - This keeps the device-side address phase stable per OBI.
  - A host must not retract req before gnt; retraction is not handled.
- Handshake: push sel into the owner FIFO and update last-granted = sel.
- Response:
  - On dev_rvalid_i, if FIFO not empty: pop the head; h[head]_rvalid_o = 1, h[head]_rdata_o = dev_rdata_i.
  - The other host sees rvalid 0.
  - rdata outputs are dev_rdata_i unconditionally; only rvalid is qualified.
- Push and pop in the same cycle: both occur, count unchanged.
- Full: no new device request is issued, even if a pop happens that cycle. The full check uses the registered count. When full and unlocked, the lock is not set because dev_req_o = 0.
- Empty with dev_rvalid_i = 1: no host rvalid, no pop, err_o set and held until reset.
- Read/write pointers wrap modulo MAX_OUTSTANDING. The count ranges 0..MAX_OUTSTANDING.
- Response latency: 0 cycles from dev_rvalid_i to hN_rvalid_o. In-order responses are assumed from the device, as the OBI protocol requires.

Test Plan:
- Single host: h1 reads addr 0x8000_0000, gnt immediate, rvalid with rdata 0x1234 two cycles later → h1_gnt_o in the request cycle, h1_rvalid_o=1 with rdata 0x1234, h0_rvalid_o=0, count returns to 0.
- Contention: both request every cycle after reset, dev_gnt_i=1 → grants alternate h0,h1,h0,h1. Responses with rdata 0xA,0xB,0xC,0xD route to h0,h1,h0,h1.
- Lock: both request, dev_gnt_i held 0 for 3 cycles → dev_addr_o stays h0_addr (0x100) all 3 cycles. h1 is granted only after h0's handshake.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid → dev_req_o=0 on the third request. One rvalid → dev_req_o reasserts the next cycle.
- Simultaneous push/pop with count=1: handshake and rvalid in the same cycle → count stays 1, head owner is correct for the next response.
- Error/reset: rvalid with the FIFO empty → err_o=1 sticky, no host rvalid. Assert rst_ni=0 asynchronously mid-transaction → err_o, count and grants clear immediately.
